// File: rtl/had_bkpt_pkg.sv
// ----------------------------------------------------------------------------
// had_bkpt_pkg
// Shared definitions for the HAD breakpoint sequencing controller.
//   - bkpt_state_t : FSM state encoding (IDLE/ARMED/REQ/DBG)
//   - SRC_A/SRC_B  : bit codes reported on had_bkpt_src
//   - CNT_W_DFLT   : default breakpoint hit counter width
// ----------------------------------------------------------------------------
package had_bkpt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REQ   = 2'd2,
        ST_DBG   = 2'd3
    } bkpt_state_t;

    localparam logic [1:0] SRC_A = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    localparam int CNT_W_DFLT = 8;

endpackage

// File: rtl/had_bkpt_cnt.sv
// ----------------------------------------------------------------------------
// had_bkpt_cnt
// Per-channel breakpoint hit counter. A counted hit on a zero counter fires;
// otherwise it decrements the counter, which saturates at zero. A register
// write in the same cycle takes precedence and the hit is dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hit        : qualified (already masked) hit for this channel
//   wen, wdata : counter load strobe and value
//   cnt        : counter value
//   fire       : channel fires this cycle (combinational)
// ----------------------------------------------------------------------------
module had_bkpt_cnt
    import had_bkpt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    input  logic             wen,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] cnt,
    output logic             fire
);

    logic hit_eff;
    logic cnt_zero;

    // A write in the same cycle swallows the hit entirely.
    assign hit_eff  = hit & ~wen;
    assign cnt_zero = (cnt == '0);
    assign fire     = hit_eff & cnt_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wen) begin
            cnt <= wdata;
        end else if (hit_eff && !cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/had_bkpt_ctrl.sv
// ----------------------------------------------------------------------------
// had_bkpt_ctrl
// Breakpoint sequencing and debug-request controller. Combines hits from two
// breakpoint comparator channels (A, B) through per-channel hit counters and
// optional A->B chaining, then raises a debug-mode request to the core and
// holds it until the core reports debug mode.
// Ports:
//   had_clk, hadrst_b              : clock, asynchronous active-low reset
//   bkpt{a,b}_{inst,data}_hit      : comparator hit pulses
//   regs_mbc{a,b}_wen, regs_mbc_wdata : counter load
//   regs_chain_en                  : A only arms B
//   iu_yy_xx_dbgon                 : core is in debug mode
//   had_core_dbg_mode_req          : registered debug-entry request
//   had_bkpt_src                   : source of last request (bit0 A, bit1 B)
//   had_mbc{a,b}_cnt               : counter readback
//   had_chain_armed                : B armed by A
// ----------------------------------------------------------------------------
module had_bkpt_ctrl
    import had_bkpt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             had_clk,
    input  logic             hadrst_b,
    input  logic             bkpta_inst_hit,
    input  logic             bkpta_data_hit,
    input  logic             bkptb_inst_hit,
    input  logic             bkptb_data_hit,
    input  logic             regs_mbca_wen,
    input  logic             regs_mbcb_wen,
    input  logic [CNT_W-1:0] regs_mbc_wdata,
    input  logic             regs_chain_en,
    input  logic             iu_yy_xx_dbgon,
    output logic             had_core_dbg_mode_req,
    output logic [1:0]       had_bkpt_src,
    output logic [CNT_W-1:0] had_mbca_cnt,
    output logic [CNT_W-1:0] had_mbcb_cnt,
    output logic             had_chain_armed
);

    bkpt_state_t state;
    bkpt_state_t state_nxt;
    logic [1:0]  src_nxt;
    logic        req_nxt;
    logic        armed_nxt;

    logic hit_a;
    logic hit_b;
    logic count_a;
    logic count_b;
    logic fire_a;
    logic fire_b;

    assign hit_a = bkpta_inst_hit | bkpta_data_hit;
    assign hit_b = bkptb_inst_hit | bkptb_data_hit;

    // Only IDLE counts A. B is counted in IDLE when unchained, or in ARMED
    // while chaining remains enabled (a chain clear in ARMED drops the B hit).
    // Nothing is counted while the core is in debug mode.
    assign count_a = hit_a & ~iu_yy_xx_dbgon & (state == ST_IDLE);
    assign count_b = hit_b & ~iu_yy_xx_dbgon &
                     (((state == ST_IDLE)  & ~regs_chain_en) |
                      ((state == ST_ARMED) &  regs_chain_en));

    had_bkpt_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (had_clk),
        .rst_n (hadrst_b),
        .hit   (count_a),
        .wen   (regs_mbca_wen),
        .wdata (regs_mbc_wdata),
        .cnt   (had_mbca_cnt),
        .fire  (fire_a)
    );

    had_bkpt_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (had_clk),
        .rst_n (hadrst_b),
        .hit   (count_b),
        .wen   (regs_mbcb_wen),
        .wdata (regs_mbc_wdata),
        .cnt   (had_mbcb_cnt),
        .fire  (fire_b)
    );

    // State and registered outputs
    always_ff @(posedge had_clk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            state                 <= ST_IDLE;
            had_bkpt_src          <= 2'b00;
            had_core_dbg_mode_req <= 1'b0;
            had_chain_armed       <= 1'b0;
        end else begin
            state                 <= state_nxt;
            had_bkpt_src          <= src_nxt;
            had_core_dbg_mode_req <= req_nxt;
            had_chain_armed       <= armed_nxt;
        end
    end

    // Next-state logic; src only changes on a request-producing fire.
    always_comb begin
        state_nxt = state;
        src_nxt   = had_bkpt_src;
        case (state)
            ST_IDLE: begin
                if (regs_chain_en) begin
                    if (fire_a) state_nxt = ST_ARMED;
                end else if (fire_a || fire_b) begin
                    state_nxt = ST_REQ;
                    src_nxt   = {fire_b, fire_a};
                end
            end
            ST_ARMED: begin
                if (!regs_chain_en) begin
                    state_nxt = ST_IDLE;
                end else if (fire_b) begin
                    state_nxt = ST_REQ;
                    src_nxt   = SRC_B;
                end
            end
            ST_REQ: begin
                if (iu_yy_xx_dbgon) state_nxt = ST_DBG;
            end
            ST_DBG: begin
                if (!iu_yy_xx_dbgon) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the next state, registered alongside the state.
    always_comb begin
        req_nxt   = (state_nxt == ST_REQ);
        armed_nxt = (state_nxt == ST_ARMED);
    end

endmodule

// File: tb/tb_had_bkpt_ctrl.sv
module tb_had_bkpt_ctrl;

    localparam int CNT_W = 8;

    logic             had_clk = 1'b0;
    logic             hadrst_b;
    logic             bkpta_inst_hit;
    logic             bkpta_data_hit;
    logic             bkptb_inst_hit;
    logic             bkptb_data_hit;
    logic             regs_mbca_wen;
    logic             regs_mbcb_wen;
    logic [CNT_W-1:0] regs_mbc_wdata;
    logic             regs_chain_en;
    logic             iu_yy_xx_dbgon;
    logic             had_core_dbg_mode_req;
    logic [1:0]       had_bkpt_src;
    logic [CNT_W-1:0] had_mbca_cnt;
    logic [CNT_W-1:0] had_mbcb_cnt;
    logic             had_chain_armed;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 had_clk = ~had_clk;

    had_bkpt_ctrl #(.CNT_W(CNT_W)) dut (
        .had_clk               (had_clk),
        .hadrst_b              (hadrst_b),
        .bkpta_inst_hit        (bkpta_inst_hit),
        .bkpta_data_hit        (bkpta_data_hit),
        .bkptb_inst_hit        (bkptb_inst_hit),
        .bkptb_data_hit        (bkptb_data_hit),
        .regs_mbca_wen         (regs_mbca_wen),
        .regs_mbcb_wen         (regs_mbcb_wen),
        .regs_mbc_wdata        (regs_mbc_wdata),
        .regs_chain_en         (regs_chain_en),
        .iu_yy_xx_dbgon        (iu_yy_xx_dbgon),
        .had_core_dbg_mode_req (had_core_dbg_mode_req),
        .had_bkpt_src          (had_bkpt_src),
        .had_mbca_cnt          (had_mbca_cnt),
        .had_mbcb_cnt          (had_mbcb_cnt),
        .had_chain_armed       (had_chain_armed)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic step();
        @(posedge had_clk);
        #1;
    endtask

    task automatic clr_hits();
        bkpta_inst_hit = 1'b0;
        bkpta_data_hit = 1'b0;
        bkptb_inst_hit = 1'b0;
        bkptb_data_hit = 1'b0;
        regs_mbca_wen  = 1'b0;
        regs_mbcb_wen  = 1'b0;
    endtask

    task automatic handshake();
        iu_yy_xx_dbgon = 1'b1;
        step();
        iu_yy_xx_dbgon = 1'b0;
        step();
    endtask

    initial begin
        hadrst_b       = 1'b0;
        regs_mbc_wdata = '0;
        regs_chain_en  = 1'b0;
        iu_yy_xx_dbgon = 1'b0;
        clr_hits();
        step();
        step();
        chk("rst_req",   16'(had_core_dbg_mode_req), 16'h0);
        chk("rst_src",   16'(had_bkpt_src),          16'h0);
        chk("rst_cnta",  16'(had_mbca_cnt),          16'h0);
        chk("rst_cntb",  16'(had_mbcb_cnt),          16'h0);
        chk("rst_armed", 16'(had_chain_armed),       16'h0);
        hadrst_b = 1'b1;
        step();

        // Single A instruction hit with zero counter
        bkpta_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t1_req", 16'(had_core_dbg_mode_req), 16'h1);
        chk("t1_src", 16'(had_bkpt_src),          16'h1);
        step();
        chk("t1_req_hold", 16'(had_core_dbg_mode_req), 16'h1);
        iu_yy_xx_dbgon = 1'b1;
        step();
        chk("t1_req_drop", 16'(had_core_dbg_mode_req), 16'h0);
        iu_yy_xx_dbgon = 1'b0;
        step();
        chk("t1_idle_req", 16'(had_core_dbg_mode_req), 16'h0);
        chk("t1_src_hold", 16'(had_bkpt_src),          16'h1);

        // Counter of 3: three decrements, fire on the fourth hit
        regs_mbca_wen  = 1'b1;
        regs_mbc_wdata = 8'd3;
        step();
        clr_hits();
        chk("t2_load", 16'(had_mbca_cnt), 16'd3);
        for (int i = 0; i < 3; i++) begin
            bkpta_data_hit = 1'b1;
            step();
            clr_hits();
            chk("t2_dec", 16'(had_mbca_cnt), 16'(2 - i));
            chk("t2_noreq", 16'(had_core_dbg_mode_req), 16'h0);
        end
        bkpta_data_hit = 1'b1;
        step();
        clr_hits();
        chk("t2_req",  16'(had_core_dbg_mode_req), 16'h1);
        chk("t2_sat",  16'(had_mbca_cnt),          16'd0);
        handshake();

        // Chaining A -> B, mbcb = 1
        regs_chain_en  = 1'b1;
        regs_mbcb_wen  = 1'b1;
        regs_mbc_wdata = 8'd1;
        step();
        clr_hits();
        chk("t3_loadb", 16'(had_mbcb_cnt), 16'd1);
        bkptb_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t3_b_ign_cnt",   16'(had_mbcb_cnt),          16'd1);
        chk("t3_b_ign_req",   16'(had_core_dbg_mode_req), 16'h0);
        chk("t3_b_ign_armed", 16'(had_chain_armed),       16'h0);
        bkpta_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t3_armed",       16'(had_chain_armed),       16'h1);
        chk("t3_armed_noreq", 16'(had_core_dbg_mode_req), 16'h0);
        bkptb_data_hit = 1'b1;
        step();
        clr_hits();
        chk("t3_b_dec",       16'(had_mbcb_cnt),          16'd0);
        chk("t3_still_armed", 16'(had_chain_armed),       16'h1);
        bkptb_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t3_req",       16'(had_core_dbg_mode_req), 16'h1);
        chk("t3_src",       16'(had_bkpt_src),          16'h2);
        chk("t3_unarmed",   16'(had_chain_armed),       16'h0);
        handshake();
        regs_chain_en = 1'b0;

        // Simultaneous A and B fire
        bkpta_inst_hit = 1'b1;
        bkptb_data_hit = 1'b1;
        step();
        clr_hits();
        chk("t4_req", 16'(had_core_dbg_mode_req), 16'h1);
        chk("t4_src", 16'(had_bkpt_src),          16'h3);
        handshake();

        // Write wins over a same-cycle hit
        regs_mbca_wen  = 1'b1;
        regs_mbc_wdata = 8'd5;
        bkpta_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t5_wr_cnt",   16'(had_mbca_cnt),          16'd5);
        chk("t5_wr_noreq", 16'(had_core_dbg_mode_req), 16'h0);
        // Hits while the core is in debug mode are ignored
        iu_yy_xx_dbgon = 1'b1;
        bkpta_data_hit = 1'b1;
        bkptb_inst_hit = 1'b1;
        step();
        clr_hits();
        iu_yy_xx_dbgon = 1'b0;
        chk("t5_dbgon_cnta", 16'(had_mbca_cnt),          16'd5);
        chk("t5_dbgon_cntb", 16'(had_mbcb_cnt),          16'd0);
        chk("t5_dbgon_req",  16'(had_core_dbg_mode_req), 16'h0);

        // Chain clear in ARMED returns to IDLE and drops the B hit
        regs_mbca_wen  = 1'b1;
        regs_mbc_wdata = 8'd0;
        step();
        clr_hits();
        regs_chain_en  = 1'b1;
        bkpta_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t6_armed", 16'(had_chain_armed), 16'h1);
        regs_chain_en  = 1'b0;
        bkptb_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t6_clr_armed", 16'(had_chain_armed),       16'h0);
        chk("t6_clr_noreq", 16'(had_core_dbg_mode_req), 16'h0);
        step();
        chk("t6_idle_noreq", 16'(had_core_dbg_mode_req), 16'h0);

        // Asynchronous reset while requesting
        bkpta_inst_hit = 1'b1;
        step();
        clr_hits();
        chk("t7_req", 16'(had_core_dbg_mode_req), 16'h1);
        #2;
        hadrst_b = 1'b0;
        #1;
        chk("t7_rst_req",   16'(had_core_dbg_mode_req), 16'h0);
        chk("t7_rst_src",   16'(had_bkpt_src),          16'h0);
        chk("t7_rst_cnta",  16'(had_mbca_cnt),          16'h0);
        chk("t7_rst_cntb",  16'(had_mbcb_cnt),          16'h0);
        chk("t7_rst_armed", 16'(had_chain_armed),       16'h0);
        step();
        hadrst_b = 1'b1;
        step();
        chk("t7_post_req", 16'(had_core_dbg_mode_req), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
